// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with a start/done handshake.
// Handles signed or unsigned operands and holds the 2W-bit product.
module booth_mult_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 tc,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH:0]     q_q, q_d;
  logic [WIDTH+1:0]   a_q, a_d;
  logic [WIDTH+1:0]   m_sext;
  logic [WIDTH+1:0]   a_sum;
  logic               qm1_q, qm1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               done_q, done_d;

  assign m_sext = {m_q[WIDTH], m_q};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (cnt_q == CW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == RUN);
    done    = done_q;
    product = product_q;
  end

  // A is one bit wider than M_ext so the add/sub never overflows.
  always_comb begin
    case ({q_q[0], qm1_q})
      2'b01:   a_sum = a_q + m_sext;
      2'b10:   a_sum = a_q - m_sext;
      default: a_sum = a_q;
    endcase
  end

  always_comb begin
    m_d       = m_q;
    q_d       = q_q;
    a_d       = a_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        m_d   = {tc & multiplicand[WIDTH-1], multiplicand};
        q_d   = {tc & multiplier[WIDTH-1], multiplier};
        a_d   = '0;
        qm1_d = 1'b0;
        cnt_d = CW'(WIDTH + 1);
      end
    end else begin
      a_d   = {a_sum[WIDTH+1], a_sum[WIDTH+1:1]};
      q_d   = {a_sum[0], q_q[WIDTH:1]};
      qm1_d = q_q[0];
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        product_d = {a_d[WIDTH-2:0], q_d};
        done_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q       <= '0;
      q_q       <= '0;
      a_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      m_q       <= m_d;
      q_q       <= q_d;
      a_q       <= a_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: a 16-bit and an 8-bit instance,
// expected products queued at issue and popped when done is observed.
module tb_booth_mult_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        tc;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] product;

  logic        start8;
  logic        tc8;
  logic [7:0]  multiplicand8;
  logic [7:0]  multiplier8;
  logic        busy8;
  logic        done8;
  logic [15:0] product8;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] exp_q[$];

  booth_mult_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .tc(tc),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product)
  );

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .tc(tc8),
    .multiplicand(multiplicand8), .multiplier(multiplier8),
    .busy(busy8), .done(done8), .product(product8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic [15:0] m, input logic [15:0] q, input logic t);
    @(negedge clk);
    start = 1'b1;
    tc = t;
    multiplicand = m;
    multiplier = q;
    @(posedge clk);
    #1;
    start = 1'b0;
    multiplicand = 16'($urandom);
    multiplier = 16'($urandom);
    tc = 1'($urandom);
  endtask

  // Counts cycles from the one following the accepting edge until done.
  task automatic wait_done(output logic [31:0] prod, output int lat,
                           output int busy_cnt, output bit timeout);
    prod = 'x;
    lat = -1;
    busy_cnt = 0;
    timeout = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = n - 1;
        prod = product;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    start8 = 1'b0;
    tc = 1'b0;
    tc8 = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    multiplicand8 = '0;
    multiplier8 = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset16: busy=%b done=%b product=%h, expected 0 0 00000000",
               busy, done, product);
    end
    vectors++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || product8 !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset8: busy=%b done=%b product=%h, expected 0 0 0000",
               busy8, done8, product8);
    end
    rst = 1'b0;
  endtask

  task automatic test_vector(input string name, input logic [15:0] m,
                             input logic [15:0] q, input logic t,
                             input logic [31:0] expected, input bit full);
    logic [31:0] prod;
    logic [31:0] e;
    int lat;
    int bc;
    bit to;
    exp_q.push_back(expected);
    issue(m, q, t);
    wait_done(prod, lat, bc, to);
    e = exp_q.pop_front();
    vectors++;
    if (to || prod !== e) begin
      errors++;
      $display("[TB] FAIL %s product: got %h (timeout=%0d), expected %h", name, prod, to, e);
    end
    if (full) begin
      vectors++;
      if (lat !== 17) begin
        errors++;
        $display("[TB] FAIL %s latency: got %0d, expected 17", name, lat);
      end
      vectors++;
      if (bc !== 17) begin
        errors++;
        $display("[TB] FAIL %s busy_cycles: got %0d, expected 17", name, bc);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || product !== e) begin
        errors++;
        $display("[TB] FAIL %s after_done: done=%b product=%h, expected 0 %h", name, done, product, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prod;
    int lat;
    int bc;
    bit to;
    int extra;
    exp_q.push_back(32'd30);
    issue(16'd5, 16'd6, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1;
    multiplicand = 16'd9;
    multiplier = 16'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(prod, lat, bc, to);
    vectors++;
    if (to || prod !== exp_q.pop_front()) begin
      errors++;
      $display("[TB] FAIL b2b_first product: got %h (timeout=%0d), expected 0000001e", prod, to);
    end
    // Start in the done cycle: the block is already idle and must accept it.
    exp_q.push_back(32'd81);
    start = 1'b1;
    tc = 1'b1;
    multiplicand = 16'd9;
    multiplier = 16'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(prod, lat, bc, to);
    vectors++;
    if (to || prod !== exp_q.pop_front()) begin
      errors++;
      $display("[TB] FAIL b2b_second product: got %h (timeout=%0d), expected 00000051", prod, to);
    end
    vectors++;
    if (lat !== 17) begin
      errors++;
      $display("[TB] FAIL b2b_second latency: got %0d, expected 17", lat);
    end
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) extra++;
    end
    vectors++;
    if (extra !== 0 || product !== 32'd81) begin
      errors++;
      $display("[TB] FAIL b2b_quiet: extra_done=%0d product=%h, expected 0 00000051", extra, product);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    exp_q.push_back(32'd20000);
    issue(16'd100, 16'd200, 1'b1);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(exp_q.size() - 1);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset state: busy=%b done=%b product=%h, expected 0 0 00000000",
               busy, done, product);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    vectors++;
    if (seen !== 0 || product !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset quiet: active_cycles=%0d product=%h, expected 0 00000000",
               seen, product);
    end
    test_vector("after_reset_12x12", 16'd12, 16'd12, 1'b1, 32'd144, 1'b0);
  endtask

  task automatic test_width8();
    logic [15:0] prod;
    int lat;
    exp_q.push_back(32'h0080);
    @(negedge clk);
    start8 = 1'b1;
    tc8 = 1'b1;
    multiplicand8 = 8'h80;
    multiplier8 = 8'hFF;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    multiplicand8 = 8'h5A;
    multiplier8 = 8'h3C;
    lat = -1;
    prod = 'x;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done8) begin
        lat = n - 1;
        prod = product8;
        break;
      end
    end
    vectors++;
    if (32'(prod) !== exp_q.pop_front()) begin
      errors++;
      $display("[TB] FAIL w8 product: got %h, expected 0080", prod);
    end
    vectors++;
    if (lat !== 9) begin
      errors++;
      $display("[TB] FAIL w8 latency: got %0d, expected 9", lat);
    end
  endtask

  task automatic test_random();
    logic [15:0] m;
    logic [15:0] q;
    logic t;
    logic [31:0] e;
    logic [31:0] prod;
    int lat;
    int bc;
    bit to;
    int sm;
    int sq;
    for (int i = 0; i < 1000; i++) begin
      m = 16'($urandom);
      q = 16'($urandom);
      t = 1'($urandom_range(0, 1));
      if (t) begin
        sm = $signed(m);
        sq = $signed(q);
        e = 32'(sm * sq);
      end else begin
        e = {16'h0, m} * {16'h0, q};
      end
      exp_q.push_back(e);
      issue(m, q, t);
      wait_done(prod, lat, bc, to);
      e = exp_q.pop_front();
      vectors++;
      if (to || prod !== e) begin
        errors++;
        $display("[TB] FAIL random[%0d] tc=%b %h*%h: got %h, expected %h", i, t, m, q, prod, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vector("signed_m3x7", 16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB, 1'b1);
    test_vector("unsigned_max", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b1);
    test_vector("signed_m1xm1", 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 1'b0);
    test_vector("signed_minxmin", 16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b0);
    test_vector("signed_minxmax", 16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, 1'b0);
    test_back_to_back();
    test_reset_mid_run();
    test_width8();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Parametrised sequential radix-2 Booth multiplier with an integrated controller. It replaces the separate datapath/controller pair with one self-sequencing block that has a start/done handshake. It adds run-time signed/unsigned operand mode and a registered, held product. It sits between operand-producing logic and any consumer of a full-width 2W-bit product.

## Interface
- WIDTH, 16, operand width W in bits; legal range 2..32.
- clk  input  1  rising-edge clock; only clock in the block.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only while idle.
- tc  input  1  operand mode: 1 = two's-complement signed, 0 = unsigned; latched with the operands.
- multiplicand  input  WIDTH  operand M; latched at accepted start.
- multiplier  input  WIDTH  operand Q; latched at accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; product valid and updated in that cycle.
- product  output  2*WIDTH  result; holds until the next done or reset.

## Operation
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1.
- Accept: in IDLE, start=1 at a clock edge loads the internal registers and moves to RUN:
  - M_ext (W+1 bits) = multiplicand, sign-extended if tc=1, else zero-extended.
  - Q_ext (W+1 bits) = multiplier, extended the same way.
  - A (W+2 bits) = 0.
  - q_m1 = 0.
  - cnt = W+1.
- RUN iteration, one per clock:
  - Select on {Q_ext[0], q_m1}:
    - 01: A = A + sext(M_ext).
    - 10: A = A − sext(M_ext).
    - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A, Q_ext, q_m1} by 1. A's MSB is replicated.
  - Then cnt = cnt − 1.
- Width rule: A carries W+2 bits so that A±M never overflows, including the corners −2^(W−1) and 2^W−1. Add/sub arithmetic is modulo 2^(W+2).
- Completion: the iteration that takes cnt from 1 to 0 also does three things at the same edge:
  - Registers product = low 2W bits of {A, Q_ext} after the shift.
  - Sets done=1 for the next cycle.
  - Returns the FSM to IDLE.
- The result is exact for both modes: the signed product of W-bit operands fits 2W bits two's-complement; the unsigned product fits 2W bits.
- start while busy=1 is ignored. It is not queued, and the in-flight operation and its operands are unaffected.
- Operand inputs are don't-care except at the accepting edge.
- A start in the same cycle as done (FSM already in IDLE) is accepted, giving back-to-back operations.
- rst=1 at any edge, including mid-RUN, has the following effect:
  - FSM goes to IDLE; busy=0, done=0, product=0, A=0, q_m1=0, cnt=0.
  - The pending operation is discarded and no done pulse is produced.
  - rst has priority over start at the same edge.

## Timing
- Reset values: busy=0, done=0, product=0.
- start is accepted at edge k:
  - busy is high in the cycles following edges k through k+W, i.e. W+1 cycles.
  - done is high in exactly one cycle, the cycle following edge k+W+1.
  - product changes at edge k+W+1 only.
- Latency from the accepting edge to done is a fixed W+1 clocks, independent of operand values and tc.
- Throughput is one result per W+2 clocks with back-to-back starts: accepting edge plus W+1 iterations, with the next start accepted on the done cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- W=16, tc=1, M=0xFFFD (−3), Q=0x0007:
  - done exactly 17 clocks after the accepting edge.
  - product=0xFFFFFFEB (−21).
  - busy high for 17 cycles.
- W=16, tc=0, M=0xFFFF, Q=0xFFFF → product=0xFFFE0001.
- W=16, same operands with tc=1 → product=0x00000001.
- W=16, tc=1 corner case, M=0x8000, Q=0x8000 → product=0x40000000.
- W=16, tc=1, M=0x8000, Q=0x7FFF → product=0xC0008000.
- Back-to-back and start-while-busy, W=16:
  - Start 5×6 signed; pulse start again with 9×9 mid-run.
  - Required: product=30 only, with a single done.
  - Then start 9×9 in the done cycle → product=81 after another 17 clocks; no idle gap required.
- Reset mid-operation:
  - Start 100×200, assert rst for one cycle at iteration 8.
  - Required: busy=0, product=0, and no done within 40 clocks.
  - Then a fresh start of 12×12 → product=144.
- WIDTH=8, tc=1: M=0x80, Q=0xFF (−128×−1) → product=0x0080, done 9 clocks after accept.
- Randomised, both tc modes: 1000 random operand pairs, product checked against a reference multiply.
